// File: rtl/sbx_pkg.sv
// Shared definitions for the W-track switch box: side numbering, select encoding,
// config FSM states and the per-output routing function.
package sbx_pkg;

  localparam logic [1:0] SIDE_L = 2'd0;
  localparam logic [1:0] SIDE_U = 2'd1;
  localparam logic [1:0] SIDE_R = 2'd2;
  localparam logic [1:0] SIDE_D = 2'd3;

  localparam logic [1:0] SEL_OFF = 2'b00;
  localparam int BITS_PER_TRACK = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } cfg_state_t;

  // Select k picks side (side + k) mod 4; the 2-bit add wraps for free.
  function automatic logic route_bit(input logic [3:0] sides, input logic [1:0] side,
                                     input logic [1:0] sel);
    logic [1:0] src;
    src = side + sel;
    return (sel == SEL_OFF) ? 1'b0 : sides[src];
  endfunction

endpackage

// File: rtl/sbx_track_mux.sv
// One routing track: each of the four side outputs selects from the other three
// side inputs (or drives 0) under its 2-bit field of the track's config byte.
module sbx_track_mux
  import sbx_pkg::*;
(
  input  logic [3:0]                sides,
  input  logic [BITS_PER_TRACK-1:0] cfg,
  output logic [3:0]                routed
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_side
    assign routed[gi] = route_bit(sides, 2'(gi), cfg[gi*2 +: 2]);
  end

endmodule

// File: rtl/switch_box_cfg.sv
// W-track switch box with a serial shadow config frame, atomic commit into the
// active frame, and optional registered side outputs.
module switch_box_cfg
  import sbx_pkg::*;
#(
  parameter int W       = 4,
  parameter bit REG_OUT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] l_in,
  input  logic [W-1:0] u_in,
  input  logic [W-1:0] r_in,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] l_out,
  output logic [W-1:0] u_out,
  output logic [W-1:0] r_out,
  output logic [W-1:0] d_out,
  input  logic         cfg_en,
  input  logic         cfg_din,
  output logic         cfg_dout,
  input  logic         cfg_commit,
  output logic         cfg_busy,
  output logic         cfg_full,
  output logic         cfg_done,
  output logic         cfg_err
);

  localparam int N  = W * BITS_PER_TRACK;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(N);

  logic [N-1:0]  shadow;
  logic [N-1:0]  active;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  cfg_state_t    state;
  cfg_state_t    state_next;
  logic          commit_ok;
  logic          done;
  logic          err;
  logic          err_next;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    err_next   = err;
    commit_ok  = 1'b0;

    if (cfg_en && (cnt != CNT_MAX)) begin
      cnt_next = cnt + CW'(1);
    end

    // A commit racing a shift is rejected so the copied frame is never ambiguous.
    if (cfg_commit) begin
      if ((state == FULL) && !cfg_en) begin
        commit_ok = 1'b1;
        cnt_next  = '0;
        err_next  = 1'b0;
      end else begin
        err_next = 1'b1;
      end
    end

    case (state)
      IDLE:    if (cfg_en) state_next = (cnt_next == CNT_MAX) ? FULL : SHIFT;
      SHIFT:   if (cnt_next == CNT_MAX) state_next = FULL;
      FULL:    if (commit_ok) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
      cnt    <= '0;
      state  <= IDLE;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (cfg_en) shadow <= {cfg_din, shadow[N-1:1]};
      if (commit_ok) active <= shadow;
      cnt   <= cnt_next;
      state <= state_next;
      done  <= commit_ok;
      err   <= err_next;
    end
  end

  assign cfg_dout = shadow[0];
  assign cfg_busy = (state == SHIFT);
  assign cfg_full = (state == FULL);
  assign cfg_done = done;
  assign cfg_err  = err;

  logic [W-1:0] route_l;
  logic [W-1:0] route_u;
  logic [W-1:0] route_r;
  logic [W-1:0] route_d;

  for (genvar gi = 0; gi < W; gi++) begin : g_track
    logic [3:0] routed;
    sbx_track_mux u_mux (
      .sides  ({d_in[gi], r_in[gi], u_in[gi], l_in[gi]}),
      .cfg    (active[gi*BITS_PER_TRACK +: BITS_PER_TRACK]),
      .routed (routed)
    );
    assign route_l[gi] = routed[SIDE_L];
    assign route_u[gi] = routed[SIDE_U];
    assign route_r[gi] = routed[SIDE_R];
    assign route_d[gi] = routed[SIDE_D];
  end

  if (REG_OUT) begin : g_reg_out
    logic [W-1:0] l_q;
    logic [W-1:0] u_q;
    logic [W-1:0] r_q;
    logic [W-1:0] d_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        l_q <= '0;
        u_q <= '0;
        r_q <= '0;
        d_q <= '0;
      end else begin
        l_q <= route_l;
        u_q <= route_u;
        r_q <= route_r;
        d_q <= route_d;
      end
    end
    assign l_out = l_q;
    assign u_out = u_q;
    assign r_out = r_q;
    assign d_out = d_q;
  end else begin : g_comb_out
    assign l_out = route_l;
    assign u_out = route_u;
    assign r_out = route_r;
    assign d_out = route_d;
  end

endmodule
